// File: rtl/comb_lock_param.sv
// Parameterised combination lock: symbols are matched one per sym_valid edge,
// with OPEN and LOCKOUT windows timed by a shared down-counter.
module comb_lock_param #(
    parameter int                        WIDTH          = 3,
    parameter int                        LENGTH         = 3,
    parameter logic [WIDTH*LENGTH-1:0]   DEFAULT_CODE   = 9'b011_110_101,
    parameter int                        MAX_FAIL       = 3,
    parameter int                        LOCKOUT_CYCLES = 16,
    parameter int                        OPEN_CYCLES    = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [WIDTH-1:0]                  switch,
    input  logic                              sym_valid,
    input  logic                              prog_en,
    input  logic [WIDTH*LENGTH-1:0]           prog_code,
    output logic                              led,
    output logic                              locked_out,
    output logic [$clog2(LENGTH+1)-1:0]       progress,
    output logic [3:0]                        fail_cnt
);

    localparam int PW   = $clog2(LENGTH + 1);
    localparam int CW   = WIDTH * LENGTH;
    localparam int TMAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int TW   = ($clog2(TMAX) < 1) ? 1 : $clog2(TMAX);

    localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [3:0]    MAXF      = 4'(MAX_FAIL);

    typedef enum logic [1:0] {S_SEARCH, S_OPEN, S_LOCKOUT} state_t;

    state_t          r_state;
    logic [TW-1:0]   r_timer;
    logic [PW-1:0]   r_progress;
    logic [3:0]      r_fail;
    logic            r_led;
    logic            r_locked;
    logic [CW-1:0]   r_code;

    logic [WIDTH-1:0] w_sym_cur;
    logic             w_match;
    logic             w_first_match;
    logic             w_last;
    logic [3:0]       w_fail_next;

    always_comb begin
        w_sym_cur = r_code[WIDTH-1:0];
        for (int i = 0; i < LENGTH; i++) begin
            if (r_progress == PW'(i)) w_sym_cur = r_code[i*WIDTH +: WIDTH];
        end
    end

    assign w_match       = (switch == w_sym_cur);
    assign w_first_match = (switch == r_code[WIDTH-1:0]);
    assign w_last        = (r_progress == PW'(LENGTH - 1));
    assign w_fail_next   = r_fail + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_SEARCH;
            r_timer    <= '0;
            r_progress <= '0;
            r_fail     <= '0;
            r_led      <= 1'b0;
            r_locked   <= 1'b0;
            r_code     <= DEFAULT_CODE;
        end else begin
            case (r_state)
                S_SEARCH: begin
                    if (sym_valid) begin
                        if (w_match) begin
                            if (w_last) begin
                                r_state    <= S_OPEN;
                                r_led      <= 1'b1;
                                r_progress <= '0;
                                r_fail     <= '0;
                                r_timer    <= OPEN_LOAD;
                            end else begin
                                r_progress <= r_progress + 1'b1;
                            end
                        end else if (r_progress != '0) begin
                            if (w_fail_next == MAXF) begin
                                r_state    <= S_LOCKOUT;
                                r_locked   <= 1'b1;
                                r_fail     <= '0;
                                r_progress <= '0;
                                r_timer    <= LOCK_LOAD;
                            end else begin
                                r_fail     <= w_fail_next;
                                r_progress <= w_first_match ? PW'(1) : '0;
                            end
                        end
                    end
                end
                S_OPEN: begin
                    // New code is only consulted in SEARCH, so loading it here is safe.
                    if (prog_en) r_code <= prog_code;
                    if (r_timer == '0) begin
                        r_state    <= S_SEARCH;
                        r_led      <= 1'b0;
                        r_progress <= '0;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_LOCKOUT: begin
                    if (r_timer == '0) begin
                        r_state    <= S_SEARCH;
                        r_locked   <= 1'b0;
                        r_progress <= '0;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                default: begin
                    r_state  <= S_SEARCH;
                    r_led    <= 1'b0;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign led        = r_led;
    assign locked_out = r_locked;
    assign progress   = r_progress;
    assign fail_cnt   = r_fail;

endmodule
